nco_tone_gen: RTL and testbench
===============================

// Module: nco_tone_gen
// PURPOSE
//  Numerically controlled oscillator that generates the signed sine stimulus the
//  pll block locks onto, i.e. the transmit end of the PLL's sample input.
//  It has a phase accumulator with a runtime frequency/phase config handshake and
//  a quarter-wave sine LUT. Output is an 8-bit signed sample stream with
//  valid/ready backpressure. It sits upstream of pll in DSP datapaths and benches.
// PARAMETERS
//  PHASE_W  16  phase accumulator / FCW width (bits)
//  LUT_AW   6   quarter-wave LUT address width (2**LUT_AW entries)
//  DATA_W   8   output sample width, two's complement
// PORTS
//  i_clk          in   1        system clock; all logic on rising edge
//  i_reset        in   1        synchronous, active-high reset
//  i_en           in   1        1 = issue samples; 0 = stop issuing, drain pipeline
//  i_cfg_valid    in   1        config word valid
//  o_cfg_ready    out  1        config accepted when valid & ready
//  i_cfg_fcw      in   PHASE_W  frequency control word (phase increment/sample)
//  i_cfg_phase    in   PHASE_W  one-shot phase jump added on acceptance
//  o_valid        out  1        o_data holds a sample
//  i_ready        in   1        downstream accepts sample when valid & ready
//  o_data         out  DATA_W   signed sine sample
//  o_phase        out  PHASE_W  accumulator phase that produced o_data
//  o_busy         out  1        state != IDLE
// BEHAVIOUR
//  Reset (i_reset=1 at edge): acc=0, fcw=0, state=IDLE, all pipeline valids=0,
//   o_valid=0, o_data=0, o_phase=0, o_busy=0. Mid-operation reset discards
//   in-flight samples the same cycle.
//  stall = o_valid & ~i_ready. On stall, every pipeline stage and acc hold.
//   o_data and o_phase must stay stable while o_valid=1 and i_ready=0.
//  o_cfg_ready = ~stall (combinational). On accept: fcw<=i_cfg_fcw and
//   acc<=acc+i_cfg_phase. The issue step in the same cycle uses the old acc/fcw.
//   The new fcw applies from the next issue.
//  Issue: in RUN with ~stall, stage0 captures acc and acc<=acc+fcw (mod 2**PHASE_W).
//   Accept+issue in the same cycle: acc<=acc+fcw_old+i_cfg_phase.
//  Pipeline, 3 cycles issue->o_valid:
//   S1 quadrant q=phase[PW-1:PW-2], addr=phase[PW-3 -: LUT_AW]; q[0] -> addr=~addr
//   S2 LUT read (registered), mag unsigned 0..127
//   S3 o_data = q[1] ? -mag : mag; o_phase is the S0 phase delayed to match.
//  LUT[k] = round(127*sin((k+0.5)*pi/2/2**LUT_AW)); output is symmetric in
//   [-127,+127] and never -128.
//  FSM: IDLE -(i_en)-> RUN. RUN -(~i_en)-> DRAIN. DRAIN -(i_en)-> RUN.
//   DRAIN -(pipeline+output empty)-> IDLE. acc and fcw are kept across IDLE
//   (phase-continuous restart). No issue occurs in IDLE/DRAIN.
//  Throughput is 1 sample/cycle with i_ready held high. fcw=0 gives a constant
//   sample. Accumulator wrap is silent modulo arithmetic.
// TESTING
//  T1 reset, cfg fcw=0x4000 phase=0, i_en=1, i_ready=1 -> first o_valid 3 cycles
//     after first issue; o_data repeats +2,+127,-2,-127; o_phase 0,4000,8000,C000.
//  T2 T1 running, i_ready low 5 cycles mid-stream -> o_data/o_phase frozen.
//     Sequence resumes with no sample dropped or duplicated.
//  T3 cfg fcw=0x2000 accepted mid-stream -> the sample issued in the acceptance
//     cycle still uses step 0x4000. Later o_phase steps are 0x2000.
//  T4 cfg phase=0x8000 with fcw=0 -> o_data flips from +2 to -2 and holds there.
//     o_cfg_ready=0 during stall.
//  T5 i_en low while running -> DRAIN, exactly the in-flight samples emerge, then
//     IDLE with o_busy=0. Re-enable continues at the next phase.
//  T6 i_reset asserted with 3 samples in flight -> next cycle o_valid=0,
//     o_data=0, state IDLE, acc=0.

Source files
------------

// File: rtl/nco_tone_gen.sv
// nco_tone_gen: phase-accumulator NCO with config handshake, quarter-wave sine LUT and valid/ready sample output
module nco_tone_gen #(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int DATA_W  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_en,
  input  logic                      i_cfg_valid,
  output logic                      o_cfg_ready,
  input  logic [PHASE_W-1:0]        i_cfg_fcw,
  input  logic [PHASE_W-1:0]        i_cfg_phase,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [DATA_W-1:0]  o_data,
  output logic [PHASE_W-1:0]        o_phase,
  output logic                      o_busy
);
  localparam logic [6:0] LUT [2**LUT_AW] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [PHASE_W-1:0] acc, fcw, p0, ph1, ph2;
  logic [LUT_AW-1:0] addr1;
  logic [6:0] mag2;
  logic v0, v1, v2, sign1, sign2, stall, issue, accept;
  assign stall = o_valid & ~i_ready;
  assign o_cfg_ready = ~stall;
  assign accept = i_cfg_valid & ~stall;
  assign issue = (state == RUN) & ~stall;
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_en) state_n = RUN;
      RUN:     if (!i_en) state_n = DRAIN;
      DRAIN:   state_n = i_en ? RUN : (v0 | v1 | v2 | o_valid) ? DRAIN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      acc     <= '0;
      fcw     <= '0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      o_valid <= 1'b0;
      p0      <= '0;
      ph1     <= '0;
      ph2     <= '0;
      sign1   <= 1'b0;
      sign2   <= 1'b0;
      addr1   <= '0;
      mag2    <= '0;
      o_data  <= '0;
      o_phase <= '0;
    end else begin
      state <= state_n;
      acc   <= acc + (issue ? fcw : '0) + (accept ? i_cfg_phase : '0);
      if (accept) fcw <= i_cfg_fcw;
      if (!stall) begin
        v0      <= issue;
        p0      <= acc;
        v1      <= v0;
        ph1     <= p0;
        sign1   <= p0[PHASE_W-1];
        addr1   <= p0[PHASE_W-2] ? ~p0[PHASE_W-3 -: LUT_AW] : p0[PHASE_W-3 -: LUT_AW];
        v2      <= v1;
        ph2     <= ph1;
        sign2   <= sign1;
        mag2    <= LUT[addr1];
        o_valid <= v2;
        o_phase <= ph2;
        o_data  <= sign2 ? -DATA_W'(mag2) : DATA_W'(mag2);
      end
    end
  end
endmodule

// File: tb/tb_nco_tone_gen.sv
// tb_nco_tone_gen: directed and randomized self-checking bench for nco_tone_gen against a sample-queue model
module tb_nco_tone_gen;
  localparam real PI = 3.14159265358979;
  logic clk = 0, rst = 1, en = 0, cv = 0, rdy = 0;
  logic [15:0] fcw_in = 0, ph_in = 0;
  logic cfg_ready, valid, busy;
  logic signed [7:0] data;
  logic [15:0] phase;
  int checks = 0, failures = 0;
  typedef struct {logic [15:0] ph; int rem;} smp_t;
  typedef struct {int d; logic [15:0] ph;} obs_t;
  smp_t pq[$];
  obs_t obs[$];
  logic [15:0] macc = 0, mfcw = 0;
  int mst = 0;
  bit chk_en = 0;

  nco_tone_gen dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_cfg_valid(cv), .o_cfg_ready(cfg_ready),
    .i_cfg_fcw(fcw_in), .i_cfg_phase(ph_in), .o_valid(valid), .i_ready(rdy),
    .o_data(data), .o_phase(phase), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic signed [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sine_of(logic [15:0] ph);
    real s;
    int r;
    s = $sin(2.0 * PI * (real'(ph[15:8]) + 0.5) / 256.0);
    r = $rtoi((s < 0.0 ? -s : s) * 127.0 + 0.5);
    return s < 0.0 ? -r : r;
  endfunction

  function automatic bit exp_valid();
    return pq.size() != 0 && pq[0].rem == 0;
  endfunction

  task automatic model_step();
    bit stall, issue, ok, empty;
    if (rst) begin
      pq.delete();
      macc = 0;
      mfcw = 0;
      mst = 0;
      return;
    end
    stall = exp_valid() && !rdy;
    issue = mst == 1 && !stall;
    ok = cv && !stall;
    empty = pq.size() == 0;
    if (!stall) begin
      if (exp_valid()) void'(pq.pop_front());
      for (int i = 0; i < pq.size(); i++) pq[i].rem--;
    end
    if (issue) pq.push_back(smp_t'{ph: macc, rem: 3});
    macc = macc + (issue ? mfcw : 16'h0) + (ok ? ph_in : 16'h0);
    if (ok) mfcw = fcw_in;
    if (mst == 0) mst = en ? 1 : 0;
    else if (mst == 1) mst = en ? 1 : 2;
    else mst = en ? 1 : (empty ? 0 : 2);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(logic e, logic r, logic c, logic [15:0] f, logic [15:0] p);
    en = e; rdy = r; cv = c; fcw_in = f; ph_in = p;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  always @(negedge clk) if (chk_en) begin
    bit ev;
    ev = exp_valid();
    chk("o_valid", 32'(valid), ev);
    chk("o_cfg_ready", 32'(cfg_ready), !(ev && !rdy));
    chk("o_busy", 32'(busy), mst != 0);
    if (ev) begin
      chk("o_data", 32'(data), sine_of(pq[0].ph));
      chk("o_phase", 32'(phase), pq[0].ph);
    end
    if (valid && rdy) obs.push_back(obs_t'{d: int'(data), ph: phase});
  end

  initial begin
    int ed[4];
    logic [15:0] ep[4];
    ed = '{2, 127, -2, -127};
    ep = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    repeat (2) cycle();
    rst = 0;
    chk_en = 1;
    chk("reset_valid", 32'(valid), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_phase", 32'(phase), 0);
    chk("reset_busy", 32'(busy), 0);
    // T1: basic tone, latency
    set_in(1, 1, 1, 16'h4000, 16'h0);
    cycle();
    cv = 0;
    repeat (3) cycle();
    chk("t1_latency_early", 32'(valid), 0);
    cycle();
    chk("t1_latency_first", 32'(valid), 1);
    chk("t1_first_data", 32'(data), 2);
    repeat (8) cycle();
    if (obs.size() < 4) chk("t1_sample_count", obs.size(), 4);
    else for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_data%0d", i), obs[i].d, ed[i]);
      chk($sformatf("t1_phase%0d", i), 32'(obs[i].ph), ep[i]);
    end
    // T2: backpressure, no drop/duplicate
    rdy = 0;
    repeat (5) cycle();
    rdy = 1;
    repeat (6) cycle();
    for (int i = 1; i < obs.size(); i++) chk("t2_step", 32'(16'(obs[i].ph - obs[i-1].ph)), 16'h4000);
    // T3: fcw change mid-stream
    obs.delete();
    set_in(1, 1, 1, 16'h2000, 16'h0);
    cycle();
    cv = 0;
    repeat (12) cycle();
    if (obs.size() < 10) chk("t3_sample_count", obs.size(), 10);
    else for (int i = 1; i < 10; i++) chk($sformatf("t3_step%0d", i), 32'(16'(obs[i].ph - obs[i-1].ph)), i <= 5 ? 16'h4000 : 16'h2000);
    // T4: phase jump with fcw=0, config blocked during stall
    do_reset();
    set_in(1, 1, 1, 16'h0, 16'h0);
    cycle();
    cv = 0;
    repeat (6) cycle();
    chk("t4_const_data", 32'(data), 2);
    set_in(1, 1, 1, 16'h0, 16'h8000);
    cycle();
    cv = 0;
    repeat (6) cycle();
    chk("t4_jump_data", 32'(data), -2);
    chk("t4_jump_phase", 32'(phase), 16'h8000);
    set_in(1, 0, 1, 16'h0, 16'h4000);
    #1;
    chk("t4_cfg_ready_stall", 32'(cfg_ready), 0);
    repeat (3) cycle();
    set_in(1, 1, 0, 16'h0, 16'h0);
    repeat (6) cycle();
    chk("t4_hold_data", 32'(data), -2);
    // T5: drain
    do_reset();
    set_in(1, 1, 1, 16'h4000, 16'h0);
    cycle();
    cv = 0;
    repeat (10) cycle();
    obs.delete();
    en = 0;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) cycle();
    chk("t5_idle", 32'(busy), 0);
    chk("t5_drain_count", obs.size(), 5);
    repeat (3) cycle();
    chk("t5_idle_valid", 32'(valid), 0);
    en = 1;
    repeat (8) cycle();
    // T6: reset with samples in flight
    do_reset();
    set_in(1, 1, 1, 16'h4000, 16'h0);
    cycle();
    cv = 0;
    repeat (5) cycle();
    rst = 1;
    cycle();
    chk("t6_valid", 32'(valid), 0);
    chk("t6_data", 32'(data), 0);
    chk("t6_phase", 32'(phase), 0);
    chk("t6_busy", 32'(busy), 0);
    rst = 0;
    repeat (6) cycle();
    chk("t6_restart_data", 32'(data), 2);
    chk("t6_restart_phase", 32'(phase), 0);
    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      rdy = $urandom_range(0, 3) != 0;
      cv = $urandom_range(0, 9) == 0;
      fcw_in = 16'($urandom);
      ph_in = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0;
      rst = $urandom_range(0, 499) == 0;
      cycle();
    end
    set_in(0, 1, 0, 16'h0, 16'h0);
    rst = 0;
    repeat (10) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
